capture_snaplen_trunc: RTL and testbench

Sits on port 1 (capture copy) downstream of the packet duplicator, between it and the DMA output queue. Truncates each captured packet to a software-programmed snap length, fixes tlast/tstrb on the cut beat, and rewrites the tuser length field. Silently consumes the discarded tail so the duplicator is never stalled by dropped bytes. Keeps packet and truncation counters for the register block.

---
 rtl/capture_snaplen_trunc_pkg.sv | 28 ++
 rtl/capture_snaplen_trunc_out_slice.sv | 44 ++++
 rtl/capture_snaplen_trunc.sv | 137 +++++++++++++
 tb/tb_capture_snaplen_trunc.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_snaplen_trunc_pkg.sv
// Shared definitions for the capture-port snap-length truncator:
// tuser length field location, FSM states and the effective-snap helper.
package capture_snaplen_trunc_pkg;

  localparam int TUSER_LEN_LSB       = 0;
  localparam int TUSER_LEN_W         = 16;
  localparam int MIN_SNAPLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // A zero snaplen disables truncation; anything else is clamped up to the minimum.
  function automatic logic [15:0] eff_snap(input logic [15:0] snap,
                                           input logic [15:0] min_snap);
    logic [15:0] eff;
    if (snap == 16'd0)
      eff = 16'd0;
    else if (snap < min_snap)
      eff = min_snap;
    else
      eff = snap;
    return eff;
  endfunction

endpackage

// File: rtl/capture_snaplen_trunc_out_slice.sv
// Single-entry registered AXI-Stream stage; accepts a new beat whenever it is
// empty or its current beat is leaving in the same cycle.
module axis_out_slice #(
  parameter int DATA_W = 256,
  parameter int STRB_W = 32,
  parameter int USER_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [STRB_W-1:0] up_strb,
  input  logic [USER_W-1:0] up_user,
  input  logic              up_last,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [STRB_W-1:0] dn_strb,
  output logic [USER_W-1:0] dn_user,
  output logic              dn_last
);

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_strb  <= '0;
      dn_user  <= '0;
      dn_last  <= 1'b0;
    end else if (up_valid && up_ready) begin
      dn_valid <= 1'b1;
      dn_data  <= up_data;
      dn_strb  <= up_strb;
      dn_user  <= up_user;
      dn_last  <= up_last;
    end else if (dn_ready) begin
      dn_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/capture_snaplen_trunc.sv
// Capture-copy truncator: cuts each packet to the programmed snap length,
// rewrites the tuser length, and silently swallows the discarded tail.
module capture_snaplen_trunc
  import capture_snaplen_trunc_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int MIN_SNAPLEN          = MIN_SNAPLEN_DEFAULT
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic [15:0]                       snaplen,
  output logic [31:0]                       pkt_count,
  output logic [31:0]                       trunc_count
);

  localparam int          BPB   = C_M_AXIS_DATA_WIDTH / 8;
  localparam logic [16:0] BPB17 = 17'(BPB);

  state_t                            state;
  logic [15:0]                       byte_count;
  logic [15:0]                       eff_q;
  logic [15:0]                       len_q;
  logic [15:0]                       in_len;
  logic [15:0]                       eff_now;
  logic [15:0]                       cur_eff;
  logic [15:0]                       cur_len;
  logic [16:0]                       count_plus;
  logic [16:0]                       remain;
  logic                              cut;
  logic                              trunc_pkt;
  logic                              slice_ready;
  logic                              accept;
  logic                              fwd_valid;
  logic [BPB-1:0]                    cut_strb;
  logic [BPB-1:0]                    fwd_strb;
  logic                              fwd_last;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   fwd_user;

  assign in_len  = s_axis_tuser[TUSER_LEN_LSB +: TUSER_LEN_W];
  assign eff_now = eff_snap(snaplen, 16'(MIN_SNAPLEN));

  // The header beat uses live snaplen/length; later beats use the values latched on it.
  assign cur_eff    = (state == ST_HEAD) ? eff_now : eff_q;
  assign cur_len    = (state == ST_HEAD) ? in_len  : len_q;
  assign trunc_pkt  = (eff_now != 16'd0) && (eff_now < in_len);
  assign count_plus = {1'b0, byte_count} + BPB17;
  assign remain     = {1'b0, cur_eff} - {1'b0, byte_count};
  assign cut        = (cur_eff != 16'd0) && (count_plus >= {1'b0, cur_eff})
                      && (cur_eff < cur_len);

  assign s_axis_tready = (state == ST_DROP) || slice_ready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign fwd_valid     = s_axis_tvalid && (state != ST_DROP);

  always_comb begin
    cut_strb = '0;
    for (int i = 0; i < BPB; i++)
      cut_strb[i] = (17'(i) < remain);
  end

  assign fwd_strb = cut ? cut_strb : s_axis_tstrb;
  assign fwd_last = cut || s_axis_tlast;

  always_comb begin
    fwd_user = s_axis_tuser;
    if (state == ST_HEAD && trunc_pkt)
      fwd_user[TUSER_LEN_LSB +: TUSER_LEN_W] = eff_now;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state       <= ST_HEAD;
      byte_count  <= 16'd0;
      eff_q       <= 16'd0;
      len_q       <= 16'd0;
      pkt_count   <= 32'd0;
      trunc_count <= 32'd0;
    end else if (accept) begin
      if (state == ST_HEAD) begin
        pkt_count <= pkt_count + 32'd1;
        eff_q     <= eff_now;
        len_q     <= in_len;
      end
      if (state == ST_DROP) begin
        if (s_axis_tlast)
          state <= ST_HEAD;
      end else if (cut) begin
        trunc_count <= trunc_count + 32'd1;
        byte_count  <= 16'd0;
        state       <= s_axis_tlast ? ST_HEAD : ST_DROP;
      end else if (s_axis_tlast) begin
        byte_count <= 16'd0;
        state      <= ST_HEAD;
      end else begin
        byte_count <= count_plus[15:0];
        state      <= ST_PASS;
      end
    end
  end

  axis_out_slice #(
    .DATA_W (C_M_AXIS_DATA_WIDTH),
    .STRB_W (BPB),
    .USER_W (C_M_AXIS_TUSER_WIDTH)
  ) u_out_slice (
    .clk      (axi_aclk),
    .rst_n    (axi_aresetn),
    .up_valid (fwd_valid),
    .up_ready (slice_ready),
    .up_data  (s_axis_tdata),
    .up_strb  (fwd_strb),
    .up_user  (fwd_user),
    .up_last  (fwd_last),
    .dn_valid (m_axis_tvalid),
    .dn_ready (m_axis_tready),
    .dn_data  (m_axis_tdata),
    .dn_strb  (m_axis_tstrb),
    .dn_user  (m_axis_tuser),
    .dn_last  (m_axis_tlast)
  );

endmodule

// File: tb/tb_capture_snaplen_trunc.sv
// Bench for capture_snaplen_trunc: packet-level model of truncation feeding a
// queue of expected output beats, checked on every output handshake.
module tb_capture_snaplen_trunc;

  localparam int DW  = 256;
  localparam int BPB = 32;
  localparam int UW  = 128;

  typedef struct {
    logic [DW-1:0]  data;
    logic [BPB-1:0] strb;
    logic [UW-1:0]  user;
    logic           last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  s_tdata;
  logic [BPB-1:0] s_tstrb;
  logic [UW-1:0]  s_tuser;
  logic           s_tvalid;
  logic           s_tready;
  logic           s_tlast;
  logic [DW-1:0]  m_tdata;
  logic [BPB-1:0] m_tstrb;
  logic [UW-1:0]  m_tuser;
  logic           m_tvalid;
  logic           m_tready;
  logic           m_tlast;
  logic [15:0]    snaplen;
  logic [31:0]    pkt_count;
  logic [31:0]    trunc_count;

  int             checks = 0;
  int             failures = 0;
  beat_t          exp_q[$];
  beat_t          mon_exp;
  int             model_pkt = 0;
  int             model_trunc = 0;
  int             mon_beats = 0;
  int             mon_pkt_beats = 0;
  int             mon_first_len = 0;
  logic [BPB-1:0] mon_last_strb = '0;
  bit             ready_rand = 1'b0;

  always #5 clk = ~clk;

  capture_snaplen_trunc dut (
    .axi_aclk      (clk),
    .axi_aresetn   (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .snaplen       (snaplen),
    .pkt_count     (pkt_count),
    .trunc_count   (trunc_count)
  );

  task automatic check_output(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [BPB-1:0] byte_mask(input int n);
    logic [BPB-1:0] m;
    m = '0;
    for (int b = 0; b < BPB; b++)
      if (b < n) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [UW-1:0] rand_user();
    logic [UW-1:0] r;
    for (int k = 0; k < UW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Output sink backpressure: always ready, or a coin flip each cycle.
  initial forever begin
    @(posedge clk);
    #1;
    m_tready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Every output handshake is matched against the model's next expected beat.
  initial forever begin
    @(negedge clk);
    if (rst_n && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL spurious_beat actual=%0h required=no_beat", m_tdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("beat_data", m_tdata, mon_exp.data);
        check_output("beat_strb", DW'(m_tstrb), DW'(mon_exp.strb));
        check_output("beat_user", DW'(m_tuser), DW'(mon_exp.user));
        check_output("beat_last", DW'(m_tlast), DW'(mon_exp.last));
      end
      if (mon_beats == 0) mon_first_len = int'(m_tuser[15:0]);
      mon_beats++;
      if (m_tlast) begin
        mon_pkt_beats = mon_beats;
        mon_last_strb = m_tstrb;
        mon_beats = 0;
      end
    end
  end

  // Builds one packet, queues the beats the truncation rules say must come out,
  // then drives it; snaplen switches to next_snap once the header is taken.
  task automatic apply_stimulus(input int len, input logic [15:0] snap,
                                input logic [15:0] next_snap, input int reset_at);
    beat_t    in_b[$];
    beat_t    b;
    int       nin, nout, eff, out_len, cyc;
    logic     acc;
    logic [UW-1:0] user0;
    nin     = (len + BPB - 1) / BPB;
    eff     = (snap == 16'd0) ? 0 : ((int'(snap) < 64) ? 64 : int'(snap));
    out_len = (eff != 0 && eff < len) ? eff : len;
    nout    = (out_len + BPB - 1) / BPB;
    model_pkt++;
    if (out_len < len) model_trunc++;
    user0 = rand_user();
    user0[15:0] = 16'(len);
    for (int i = 0; i < nin; i++) begin
      b.data = rand_data();
      b.strb = byte_mask(len - i * BPB);
      b.user = (i == 0) ? user0 : rand_user();
      b.last = (i == nin - 1);
      in_b.push_back(b);
    end
    for (int i = 0; i < nout; i++) begin
      b = in_b[i];
      b.strb = byte_mask(out_len - i * BPB);
      b.last = (i == nout - 1);
      if (i == 0) b.user[15:0] = 16'(out_len);
      exp_q.push_back(b);
    end
    snaplen = snap;
    for (int i = 0; i < nin; i++) begin
      s_tdata  = in_b[i].data;
      s_tstrb  = in_b[i].strb;
      s_tuser  = in_b[i].user;
      s_tlast  = in_b[i].last;
      s_tvalid = 1'b1;
      acc = 1'b0;
      cyc = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_tready;
        if (i >= nout) check_output("drop_ready", DW'(s_tready), DW'(1));
        @(posedge clk);
        #1;
        cyc++;
        if (!acc && cyc > 2000) begin
          failures++;
          $display("[TB] FAIL input_stall actual=%0d_cycles required=accept", cyc);
          finish_run();
        end
      end
      if (i == 0) snaplen = next_snap;
      if (i == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_output("rst_tvalid", DW'(m_tvalid), DW'(0));
        check_output("rst_tdata", m_tdata, DW'(0));
        check_output("rst_tlast", DW'(m_tlast), DW'(0));
        check_output("rst_tuser", DW'(m_tuser), DW'(0));
        check_output("rst_pkt_count", DW'(pkt_count), DW'(0));
        check_output("rst_trunc_count", DW'(trunc_count), DW'(0));
        exp_q.delete();
        model_pkt = 0;
        model_trunc = 0;
        mon_beats = 0;
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_output(name, DW'(exp_q.size()), DW'(0));
  endtask

  task automatic check_pkt(input string name, input int beats,
                           input logic [BPB-1:0] last_strb, input int len);
    check_output({name, "_beats"}, DW'(mon_pkt_beats), DW'(beats));
    check_output({name, "_last_strb"}, DW'(mon_last_strb), DW'(last_strb));
    check_output({name, "_len"}, DW'(mon_first_len), DW'(len));
  endtask

  task automatic check_counters(input string name);
    check_output({name, "_pkt_count"}, DW'(pkt_count), DW'(model_pkt));
    check_output({name, "_trunc_count"}, DW'(trunc_count), DW'(model_trunc));
  endtask

  int            rnd_len[20];
  logic [15:0]   rnd_snap[21];

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    snaplen  = 16'd0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_tvalid", DW'(m_tvalid), DW'(0));
    check_output("reset_tdata", m_tdata, DW'(0));
    check_output("reset_pkt_count", DW'(pkt_count), DW'(0));
    check_output("reset_trunc_count", DW'(trunc_count), DW'(0));
    check_output("reset_s_tready", DW'(s_tready), DW'(1));
    rst_n = 1'b1;
    idle(2);

    apply_stimulus(100, 16'd0, 16'd0, -1);
    drain("t1_drain");
    check_pkt("t1", 4, 32'h0000000F, 100);
    check_output("t1_pkt_count", DW'(pkt_count), DW'(1));
    check_output("t1_trunc_count", DW'(trunc_count), DW'(0));

    ready_rand = 1'b1;
    apply_stimulus(1500, 16'd96, 16'd96, -1);
    drain("t2_drain");
    check_pkt("t2", 3, 32'hFFFFFFFF, 96);
    check_output("t2_trunc_count", DW'(trunc_count), DW'(1));

    apply_stimulus(200, 16'd70, 16'd70, -1);
    drain("t3a_drain");
    check_pkt("t3a", 3, 32'h0000003F, 70);
    apply_stimulus(200, 16'd10, 16'd10, -1);
    drain("t3b_drain");
    check_pkt("t3b", 2, 32'hFFFFFFFF, 64);

    apply_stimulus(128, 16'd128, 16'd128, -1);
    drain("t4a_drain");
    check_pkt("t4a", 4, 32'hFFFFFFFF, 128);
    check_output("t4a_trunc_count", DW'(trunc_count), DW'(3));
    apply_stimulus(129, 16'd128, 16'd128, -1);
    drain("t4b_drain");
    check_pkt("t4b", 4, 32'hFFFFFFFF, 128);
    check_output("t4b_trunc_count", DW'(trunc_count), DW'(4));

    apply_stimulus(80, 16'd70, 16'd0, -1);
    drain("t5a_drain");
    check_pkt("t5a", 3, 32'h0000003F, 70);
    apply_stimulus(20, 16'd0, 16'd0, -1);
    drain("t5b_drain");
    check_pkt("t5b", 1, 32'h000FFFFF, 20);
    check_counters("directed");

    for (int k = 0; k < 21; k++) begin
      case ($urandom_range(0, 5))
        0: rnd_snap[k] = 16'd0;
        1: rnd_snap[k] = 16'd10;
        2: rnd_snap[k] = 16'd64;
        3: rnd_snap[k] = 16'd70;
        4: rnd_snap[k] = 16'd96;
        default: rnd_snap[k] = 16'($urandom_range(1, 700));
      endcase
    end
    for (int k = 0; k < 20; k++) rnd_len[k] = $urandom_range(1, 600);
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(rnd_len[k], rnd_snap[k], rnd_snap[k+1], -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    drain("random_drain");
    check_counters("random");

    apply_stimulus(1000, 16'd64, 16'd64, 10);
    apply_stimulus(200, 16'd70, 16'd70, -1);
    drain("t7_drain");
    check_pkt("t7", 3, 32'h0000003F, 70);
    check_output("t7_pkt_count", DW'(pkt_count), DW'(1));
    check_output("t7_trunc_count", DW'(trunc_count), DW'(1));

    idle(4);
    finish_run();
  end

endmodule
